// File: rtl/bram_port_arbiter.sv
// Shares one RAMB36E1 port between two requesters. Arbitration is round-robin with a
// bounded burst allowance. All BRAM controls are registered; read data returns to the issuer.
module bram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int DO_REG    = 0,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic [DATA_W/8-1:0] we0,
    input  logic [DATA_W/8-1:0] we1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [DATA_W-1:0]   rdata0,
    output logic [DATA_W-1:0]   rdata1,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_di,
    output logic                ram_regce,
    input  logic [DATA_W-1:0]   ram_do
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 + DO_REG;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    req_id_t             last;
    req_id_t             winner;
    logic [CNT_W-1:0]    burst_cnt;
    logic                any_gnt;
    logic [BE_W-1:0]     win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [DEPTH-1:0]    tag_v;
    logic [DEPTH-1:0]    tag_id;

    // A zero burst count means no burst is running, so a conflict hands over to the
    // requester that did not go last; with last=REQ1 at reset, req0 wins first.
    always_comb begin
        winner = REQ0;
        if (req0 && req1) begin
            if (burst_cnt != '0 && burst_cnt < CNT_W'(BURST_MAX))
                winner = last;
            else
                winner = (last == REQ0) ? REQ1 : REQ0;
        end else if (req1) begin
            winner = REQ1;
        end
        gnt0    = !rst && req0 && (winner == REQ0);
        gnt1    = !rst && req1 && (winner == REQ1);
        any_gnt = gnt0 || gnt1;
    end

    always_comb begin
        win_we   = (winner == REQ1) ? we1    : we0;
        win_addr = (winner == REQ1) ? addr1  : addr0;
        win_data = (winner == REQ1) ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= REQ1;
            burst_cnt <= '0;
            ram_en    <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_di    <= '0;
            tag_v     <= '0;
            tag_id    <= '0;
        end else begin
            if (any_gnt) begin
                last <= winner;
                if (winner != last)
                    burst_cnt <= CNT_W'(1);
                else if (burst_cnt < CNT_W'(BURST_MAX))
                    burst_cnt <= burst_cnt + 1'b1;
                ram_en   <= 1'b1;
                ram_we   <= win_we;
                ram_addr <= win_addr;
                ram_di   <= win_data;
            end else begin
                burst_cnt <= '0;
                ram_en    <= 1'b0;
                ram_we    <= '0;
            end
            tag_v  <= {tag_v[DEPTH-2:0], any_gnt && (win_we == '0)};
            tag_id <= {tag_id[DEPTH-2:0], winner == REQ1};
        end
    end

    assign rvalid0 = tag_v[DEPTH-1] && !tag_id[DEPTH-1];
    assign rvalid1 = tag_v[DEPTH-1] &&  tag_id[DEPTH-1];
    assign rdata0  = ram_do;
    assign rdata1  = ram_do;

    // The output register must capture while the tag sits one stage before the output.
    if (DO_REG != 0) begin : g_regce
        assign ram_regce = tag_v[DEPTH-2];
    end else begin : g_no_regce
        assign ram_regce = 1'b0;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: one instance per DO_REG setting, each on a behavioural
// WRITE_FIRST BRAM, sharing stimulus; reads are checked through per-instance scoreboards.
module tb_bram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [BW-1:0] we0 = '0, we1 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;

    logic gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ram_en_a, ram_regce_a;
    logic gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ram_en_b, ram_regce_b;
    logic [DW-1:0] rdata0_a, rdata1_a, ram_di_a, ram_do_a;
    logic [DW-1:0] rdata0_b, rdata1_b, ram_di_b, ram_do_b;
    logic [BW-1:0] ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DO_REG(0), .BURST_MAX(4)) dut_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .ram_en(ram_en_a), .ram_we(ram_we_a),
        .ram_addr(ram_addr_a), .ram_di(ram_di_a), .ram_regce(ram_regce_a), .ram_do(ram_do_a)
    );

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DO_REG(1), .BURST_MAX(4)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .ram_en(ram_en_b), .ram_we(ram_we_b),
        .ram_addr(ram_addr_b), .ram_di(ram_di_b), .ram_regce(ram_regce_b), .ram_do(ram_do_b)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] di,
                                            input logic [BW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++)
            if (we[i]) r[8*i +: 8] = di[8*i +: 8];
        return r;
    endfunction

    // Behavioural RAMB36 ports: WRITE_FIRST, optional output register on instance b.
    logic [DW-1:0] mem_a [1<<AW];
    logic [DW-1:0] mem_b [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] lat_a, lat_b, oreg_b;

    always @(posedge clk) begin
        if (ram_en_a) begin
            mem_a[ram_addr_a] <= merge(mem_a[ram_addr_a], ram_di_a, ram_we_a);
            lat_a             <= merge(mem_a[ram_addr_a], ram_di_a, ram_we_a);
        end
        if (ram_en_b) begin
            mem_b[ram_addr_b] <= merge(mem_b[ram_addr_b], ram_di_b, ram_we_b);
            lat_b             <= merge(mem_b[ram_addr_b], ram_di_b, ram_we_b);
        end
        if (ram_regce_b) oreg_b <= lat_b;
    end
    assign ram_do_a = lat_a;
    assign ram_do_b = oreg_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    task automatic sb_port(input bit sel, input logic v0, input logic v1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        exp_t e;
        bit   due;
        due = sel ? (qb.size() > 0 && qb[0].due == cyc) : (qa.size() > 0 && qa[0].due == cyc);
        if (due) begin
            e = sel ? qb.pop_front() : qa.pop_front();
            check(sel ? "rvalid_b" : "rvalid_a", 64'({v1, v0}), e.id ? 64'd2 : 64'd1);
            check(sel ? "rdata_b" : "rdata_a", 64'(e.id ? d1 : d0), 64'(e.data));
        end else begin
            check(sel ? "rvalid_idle_b" : "rvalid_idle_a", 64'({v1, v0}), 64'd0);
        end
    endtask

    // Scoreboard: expected read data comes from ref_mem at grant time; writes update ref_mem.
    always @(negedge clk) begin
        exp_t          e;
        logic          id;
        logic [BW-1:0] w;
        logic [AW-1:0] ad;
        if (!rst) begin
            sb_port(1'b0, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a);
            sb_port(1'b1, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b);
            check("regce_a", 64'(ram_regce_a), 64'd0);
            check("regce_b", 64'(ram_regce_b),
                  64'(qb.size() > 0 && qb[0].due == cyc + 1));
            if (gnt0_b || gnt1_b) begin
                id = gnt1_b;
                w  = id ? we1 : we0;
                ad = id ? addr1 : addr0;
                if (w == '0) begin
                    e.id = id; e.data = ref_mem[ad]; e.due = cyc + 3;
                    qb.push_back(e);
                end
            end
            if (gnt0_a || gnt1_a) begin
                id = gnt1_a;
                w  = id ? we1 : we0;
                ad = id ? addr1 : addr0;
                if (w == '0) begin
                    e.id = id; e.data = ref_mem[ad]; e.due = cyc + 2;
                    qa.push_back(e);
                end else begin
                    ref_mem[ad] = merge(ref_mem[ad], id ? wdata1 : wdata0, w);
                end
            end
        end
    end

    typedef struct {
        logic          r0;
        logic [BW-1:0] w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic [BW-1:0] w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [1:0]    g;   // {gnt1, gnt0}
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic r0, input logic [BW-1:0] w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic r1, input logic [BW-1:0] w1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [1:0] g);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.g = g;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl_a"}, 64'({gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ram_en_a, ram_regce_a}), 64'd0);
        check({tag, "_bus_a"}, 64'({ram_we_a, ram_addr_a, ram_di_a}), 64'd0);
        check({tag, "_ctl_b"}, 64'({gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ram_en_b, ram_regce_b}), 64'd0);
        check({tag, "_bus_b"}, 64'({ram_we_b, ram_addr_b, ram_di_b}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, p;
        logic [1:0] exp_g;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = {16'h5A5A, 6'd0, 10'(i)};
            mem_a[i]   = ref_mem[i];
            mem_b[i]   = ref_mem[i];
        end
        ref_mem[5] = 32'hA5A5_0001;
        mem_a[5]   = 32'hA5A5_0001;
        mem_b[5]   = 32'hA5A5_0001;

        //        r0  we0    a0      d0             r1  we1    a1      d1             {g1,g0}
        tbl.push_back(mk(1, 4'h0, 10'h005, 32'h0,         0, 4'h0, 10'h000, 32'h0,         2'b01));
        tbl.push_back(mk(0, 4'h0, 10'h000, 32'h0,         0, 4'h0, 10'h000, 32'h0,         2'b00));
        tbl.push_back(mk(0, 4'h0, 10'h000, 32'h0,         0, 4'h0, 10'h000, 32'h0,         2'b00));
        tbl.push_back(mk(0, 4'h0, 10'h000, 32'h0,         1, 4'hF, 10'h3FF, 32'hDEADBEEF,  2'b10));
        tbl.push_back(mk(0, 4'h0, 10'h000, 32'h0,         1, 4'h0, 10'h3FF, 32'h0,         2'b10));
        tbl.push_back(mk(0, 4'h0, 10'h000, 32'h0,         0, 4'h0, 10'h000, 32'h0,         2'b00));
        tbl.push_back(mk(1, 4'h0, 10'h010, 32'h0,         1, 4'h0, 10'h020, 32'h0,         2'b01));
        tbl.push_back(mk(1, 4'h0, 10'h010, 32'h0,         1, 4'h0, 10'h020, 32'h0,         2'b01));
        tbl.push_back(mk(0, 4'h0, 10'h000, 32'h0,         1, 4'h0, 10'h020, 32'h0,         2'b10));
        tbl.push_back(mk(1, 4'h0, 10'h011, 32'h0,         0, 4'h0, 10'h000, 32'h0,         2'b01));
        tbl.push_back(mk(1, 4'h3, 10'h005, 32'h12345678,  0, 4'h0, 10'h000, 32'h0,         2'b01));
        tbl.push_back(mk(1, 4'h0, 10'h005, 32'h0,         0, 4'h0, 10'h000, 32'h0,         2'b01));
        tbl.push_back(mk(1, 4'h0, 10'h006, 32'h0,         1, 4'h0, 10'h005, 32'h0,         2'b01));
        tbl.push_back(mk(1, 4'h0, 10'h007, 32'h0,         1, 4'h0, 10'h005, 32'h0,         2'b10));
        tbl.push_back(mk(1, 4'h0, 10'h007, 32'h0,         1, 4'h0, 10'h3FF, 32'h0,         2'b10));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1, 4'h0, 10'(10'h100 + k), 32'h0, 0, 4'h0, 10'h000, 32'h0, 2'b01));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 4'h0, 10'h000, 32'h0, 0, 4'h0, 10'h000, 32'h0, 2'b00));

        #2;
        check_reset_outputs("reset_init");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(posedge clk);
            #1 apply(v);
            @(negedge clk);
            check($sformatf("gnt_a[%0d]", i), 64'({gnt1_a, gnt0_a}), 64'(v.g));
            check($sformatf("gnt_b[%0d]", i), 64'({gnt1_b, gnt0_b}), 64'(v.g));
            if (i > 0) begin
                p = tbl[i-1];
                check($sformatf("ram_en[%0d]", i), 64'(ram_en_a), 64'(p.g != 2'b00));
                if (p.g != 2'b00) begin
                    check($sformatf("ram_addr[%0d]", i), 64'(ram_addr_a), 64'(p.g[1] ? p.a1 : p.a0));
                    check($sformatf("ram_we[%0d]", i), 64'(ram_we_a), 64'(p.g[1] ? p.w1 : p.w0));
                end else begin
                    check($sformatf("ram_we_idle[%0d]", i), 64'(ram_we_a), 64'd0);
                end
            end
        end

        // Contention held from reset: req0 gets the first burst of four, then req1.
        @(posedge clk);
        #1 rst = 1'b1;
        qa.delete();
        qb.delete();
        req0 = 1'b1; we0 = '0; addr0 = 10'h010;
        req1 = 1'b1; we1 = '0; addr1 = 10'h020;
        #1 check_reset_outputs("reset_req_held");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_g = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("contend[%0d]", k), 64'({gnt1_b, gnt0_b}), 64'(exp_g));
            check($sformatf("contend_a[%0d]", k), 64'({gnt1_a, gnt0_a}), 64'(exp_g));
            @(posedge clk);
        end

        // Reset with reads still in flight: everything drops at once and nothing returns.
        #1 rst = 1'b1;
        qa.delete();
        qb.delete();
        #1 check_reset_outputs("reset_mid");
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
